// File: rtl/ripple_adder16_pkg.sv
// ---------------------------------------------------------------------------
// ripple_adder16_pkg
// Shared constants and types for the 16-bit ripple-carry adder.
//   WIDTH  : operand/sum width
//   SLICE  : bits handled by one adder slice
//   NSLICE : number of slices in the ripple chain
//   word_t : one WIDTH-bit operand/sum word
// ---------------------------------------------------------------------------
package ripple_adder16_pkg;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  typedef logic [WIDTH-1:0] word_t;

endpackage : ripple_adder16_pkg

// File: rtl/ripple_adder16_adder4_slice.sv
// ---------------------------------------------------------------------------
// adder4_slice
// Purely combinational SLICE-bit adder used as one link of the ripple chain.
// Ports:
//   a  [W-1:0] : operand A bits of this slice
//   b  [W-1:0] : operand B bits of this slice
//   ci         : carry into the slice
//   s  [W-1:0] : sum bits of this slice
//   co         : carry out of the slice
// ---------------------------------------------------------------------------
module adder4_slice
  import ripple_adder16_pkg::*;
#(
  parameter int W = SLICE
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  // Internal bit-level carries; c_s[0] is the slice carry-in.
  logic [W:0] c_s;

  // Bit-serial full-adder chain inside the slice.
  always_comb begin
    c_s    = '0;
    s      = '0;
    c_s[0] = ci;
    for (int k = 0; k < W; k++) begin
      s[k]     = a[k] ^ b[k] ^ c_s[k];
      c_s[k+1] = (a[k] & b[k]) | (c_s[k] & (a[k] ^ b[k]));
    end
    co = c_s[W];
  end

endmodule : adder4_slice

// File: rtl/ripple_adder16.sv
// ---------------------------------------------------------------------------
// ripple_adder16
// WIDTH-bit unsigned adder with carry-in built from WIDTH/SLICE ripple-chained
// slices. Sum, carry-out and every inter-slice carry are registered, giving
// one cycle of latency and one add per cycle.
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous reset, active-high (overrides in_valid)
//   a, b        : unsigned operands [WIDTH-1:0]
//   cin         : carry into slice 0
//   in_valid    : qualifies a/b/cin this cycle
//   y           : registered sum (a+b+cin) mod 2^WIDTH
//   cout        : registered carry out of the top slice
//   slice_carry : registered carry out of each slice (top bit == cout)
//   out_valid   : y/cout/slice_carry hold a new result this cycle
// WIDTH must be a multiple of SLICE.
// ---------------------------------------------------------------------------
module ripple_adder16
  import ripple_adder16_pkg::*;
#(
  parameter int WIDTH = ripple_adder16_pkg::WIDTH,
  parameter int SLICE = ripple_adder16_pkg::SLICE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     cin,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         y,
  output logic                     cout,
  output logic [WIDTH/SLICE-1:0]   slice_carry,
  output logic                     out_valid
);

  localparam int N_SLICE = WIDTH / SLICE;

  // carry_s[i] is the carry into slice i; carry_s[N_SLICE] is the final carry.
  logic [N_SLICE:0]   carry_s;
  logic [WIDTH-1:0]   sum_s;

  logic [WIDTH-1:0]   y_d,           y_q;
  logic               cout_d,        cout_q;
  logic [N_SLICE-1:0] slice_carry_d, slice_carry_q;
  logic               out_valid_d,   out_valid_q;

  assign carry_s[0] = cin;

  // Pure ripple: each slice waits on the carry of the slice below it.
  for (genvar i = 0; i < N_SLICE; i++) begin : g_slice
    adder4_slice #(
      .W (SLICE)
    ) u_slice (
      .a  (a[i*SLICE +: SLICE]),
      .b  (b[i*SLICE +: SLICE]),
      .ci (carry_s[i]),
      .s  (sum_s[i*SLICE +: SLICE]),
      .co (carry_s[i+1])
    );
  end

  // Next-state: capture a new result on in_valid, otherwise hold and drop valid.
  always_comb begin
    y_d           = y_q;
    cout_d        = cout_q;
    slice_carry_d = slice_carry_q;
    out_valid_d   = 1'b0;
    if (in_valid) begin
      y_d           = sum_s;
      cout_d        = carry_s[N_SLICE];
      slice_carry_d = carry_s[N_SLICE:1];
      out_valid_d   = 1'b1;
    end else begin
      out_valid_d   = 1'b0;
    end
  end

  // Output registers with synchronous reset taking priority over in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q           <= '0;
      cout_q        <= 1'b0;
      slice_carry_q <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      y_q           <= y_d;
      cout_q        <= cout_d;
      slice_carry_q <= slice_carry_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign y           = y_q;
  assign cout        = cout_q;
  assign slice_carry = slice_carry_q;
  assign out_valid   = out_valid_q;

endmodule : ripple_adder16

// File: tb/tb_ripple_adder16.sv
// ---------------------------------------------------------------------------
// tb_ripple_adder16
// Self-checking bench for ripple_adder16: stimulus pushes expected results
// from an arithmetic reference model into a queue; a monitor pops and
// compares whenever out_valid is seen.
// ---------------------------------------------------------------------------
module tb_ripple_adder16;

  typedef struct packed {
    logic [15:0] y;
    logic        cout;
    logic [3:0]  sc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        in_valid;
  logic [15:0] y;
  logic        cout;
  logic [3:0]  slice_carry;
  logic        out_valid;

  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_mismatch = 0;

  ripple_adder16 dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .in_valid    (in_valid),
    .y           (y),
    .cout        (cout),
    .slice_carry (slice_carry),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: every carry is just whether the low-order partial sum overflows.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                 input logic cv);
    exp_t        e;
    int unsigned ai;
    int unsigned bi;
    int unsigned ci;
    int unsigned full;
    int unsigned m;
    ai = av;
    bi = bv;
    ci = cv;
    for (int i = 1; i <= 4; i++) begin
      m = 32'd1 << (4 * i);
      e.sc[i-1] = (((ai % m) + (bi % m) + ci) >= m);
    end
    full   = ai + bi + ci;
    e.y    = full[15:0];
    e.cout = full[16];
    return e;
  endfunction

  // One cycle of stimulus; inputs change 1 time unit after the active edge.
  task automatic step(input logic r, input logic v, input logic [15:0] av,
                      input logic [15:0] bv, input logic cv);
    rst      = r;
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = cv;
    if (v && !r) exp_q.push_back(model(av, bv, cv));
    @(posedge clk);
    #1;
  endtask

  // Direct check of the registered outputs against fixed expectations.
  task automatic check_out(input string name, input logic [15:0] ey,
                           input logic ec, input logic [3:0] es,
                           input logic ev);
    n_compared++;
    if (y !== ey || cout !== ec || slice_carry !== es || out_valid !== ev) begin
      n_mismatch++;
      $display("FAIL %s: got y=%h cout=%b sc=%b ov=%b, want y=%h cout=%b sc=%b ov=%b",
               name, y, cout, slice_carry, out_valid, ey, ec, es, ev);
    end
  endtask

  // Monitor: compare each presented result against the head of the scoreboard.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatch++;
        $display("FAIL unexpected_result: got y=%h cout=%b sc=%b, want no result",
                 y, cout, slice_carry);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (y !== e.y || cout !== e.cout || slice_carry !== e.sc) begin
          n_mismatch++;
          $display("FAIL scoreboard: got y=%h cout=%b sc=%b, want y=%h cout=%b sc=%b",
                   y, cout, slice_carry, e.y, e.cout, e.sc);
        end
      end
    end
  end

  // Hard bound on run time.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, want finish before 2000000");
    $fatal(1, "timeout");
  end

  // Main stimulus sequence.
  initial begin
    logic [15:0] av;
    logic [15:0] bv;
    logic        cv;
    logic        vv;
    logic [4:0]  sel;
    exp_t        held;

    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 16'h0000;
    b        = 16'h0000;
    cin      = 1'b0;
    @(posedge clk);
    #1;

    // Reset dominates a valid all-ones input.
    step(1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    check_out("reset_state", 16'h0000, 1'b0, 4'b0000, 1'b0);

    // Baseline.
    step(1'b0, 1'b1, 16'hEEEE, 16'h0000, 1'b0);
    check_out("baseline", 16'hEEEE, 1'b0, 4'b0000, 1'b1);

    // Full carry sweep over {cin, a[12], a[8], a[4], a[0]}, back to back.
    for (int v = 0; v < 32; v++) begin
      sel = v[4:0];
      av  = 16'hEEEE;
      av[0]  = sel[0];
      av[4]  = sel[1];
      av[8]  = sel[2];
      av[12] = sel[3];
      step(1'b0, 1'b1, av, 16'h0000, sel[4]);
      if (sel == 5'b11111) check_out("sweep_all_propagate", 16'h0000, 1'b1, 4'b1111, 1'b1);
      if (sel == 5'b10001) check_out("sweep_slice0_only", 16'hEEF0, 1'b0, 4'b0001, 1'b1);
    end

    // Wrap-around and boundary cases.
    step(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    check_out("wrap_ffff_plus_cin", 16'h0000, 1'b1, 4'b1111, 1'b1);
    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    check_out("max_plus_max", 16'hFFFF, 1'b1, 4'b1111, 1'b1);
    step(1'b0, 1'b1, 16'h8000, 16'h8000, 1'b0);
    check_out("msb_overflow", 16'h0000, 1'b1, 4'b1000, 1'b1);

    // Hold: outputs keep the last result while valid is low.
    step(1'b0, 1'b1, 16'h1234, 16'hFEDC, 1'b1);
    held = model(16'h1234, 16'hFEDC, 1'b1);
    for (int h = 0; h < 3; h++) begin
      step(1'b0, 1'b0, 16'h5555, 16'hAAAA, 1'b1);
      check_out("hold", held.y, held.cout, held.sc, 1'b0);
    end

    // Reset mid-stream clears outputs; next valid input resumes normally.
    step(1'b0, 1'b1, 16'h0F0F, 16'h00F1, 1'b0);
    step(1'b1, 1'b1, 16'h7777, 16'h8889, 1'b0);
    check_out("midstream_reset", 16'h0000, 1'b0, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 16'h00FF, 16'h0001, 1'b0);
    check_out("after_reset", 16'h0100, 1'b0, 4'b0011, 1'b1);

    // Random back-to-back traffic with random in_valid.
    for (int n = 0; n < 1000; n++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      cv = 1'($urandom_range(0, 1));
      vv = ($urandom_range(0, 3) != 0);
      step(1'b0, vv, av, bv, cv);
    end

    // Drain and confirm every expected result was presented.
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatch++;
      $display("FAIL drain: got %0d results outstanding, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule : tb_ripple_adder16

// File: doc/ripple_adder16.md
Name: ripple_adder16

Overview:
- 16-bit unsigned adder with carry-in, built as a ripple chain of four 4-bit adder slices.
- Sum, carry-out and per-slice carries are registered, giving one cycle of latency.
- Generic datapath arithmetic block. It exposes the inter-slice carry chain so verification can observe every carry combination.

Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of SLICE (only 16 is required to be verified).
- SLICE, 4, bits per adder slice; the number of slices is WIDTH/SLICE.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry into slice 0.
- in_valid  input  1  qualifies a/b/cin this cycle.
- y  output  WIDTH  registered sum (a+b+cin) mod 2^WIDTH.
- cout  output  1  registered carry out of the top slice.
- slice_carry  output  WIDTH/SLICE  registered carry out of each slice; bit i is the carry out of slice i, and the top bit equals cout.
- out_valid  output  1  y/cout/slice_carry hold a new result.

Behaviour:
- Clocking: one clock domain (clk); rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset: when rst=1 at an edge, y=0, cout=0, slice_carry=0, out_valid=0. Reset overrides in_valid in the same cycle.
- Combinational core:
  - Slice i adds a[4i+3:4i] + b[4i+3:4i] + c_i, with c_0=cin and c_(i+1)=carry out of slice i.
  - Pure ripple between slices; no carry lookahead across slices.
  - Internal slice logic is free, but the result must be exact.
- Registration: at an edge with rst=0 and in_valid=1:
  - y <= sum, cout <= c_4, slice_carry <= {c_4,c_3,c_2,c_1}.
  - out_valid <= 1.
- Hold: at an edge with rst=0 and in_valid=0, y/cout/slice_carry hold their previous values and out_valid <= 0.
- Latency: exactly 1 cycle from sampled inputs to outputs. Throughput is one add per cycle; back-to-back in_valid is allowed. There is no backpressure.
- Arithmetic: {cout,y} == a + b + cin as an unsigned 17-bit value.
- Wrap-around: 0xFFFF+0x0000+1 gives y=0x0000, cout=1.
- Full propagate chain: all slices propagate and cin=1, so every slice_carry bit is 1 and the chain is resolved within one cycle.
- No X propagation from unused state: outputs are defined after the first reset.
- Reset mid-stream: a result in flight is discarded; the next valid input after reset produces its result one cycle later.

Decomposition:
- Shared package: constants WIDTH=16, SLICE=4, NSLICE=WIDTH/SLICE; typedef for the WIDTH-bit word.
- One natural sub-module: adder4_slice, with inputs a[3:0], b[3:0], ci and outputs s[3:0], co.
  - It is instantiated NSLICE times via a generate loop and is combinational only.
- The top level holds the carry chain wiring plus output registers.

Test Plan:
- Reset: drive rst=1 with in_valid=1, a=0xFFFF, cin=1 -> next cycle y=0x0000, cout=0, slice_carry=0000, out_valid=0.
- Baseline: a=0xEEEE, b=0x0000, cin=0, in_valid=1 -> one cycle later y=0xEEEE, cout=0, slice_carry=0000, out_valid=1.
- Full carry sweep:
  - Fix a=0xEEEE, b=0; iterate {cin,a[12],a[8],a[4],a[0]} over 0..31, one vector per cycle.
  - Example: 0b11111 gives a=0xFFFF, y=0x0000, cout=1, slice_carry=1111.
  - Example: 0b10001 gives a=0xEEEF, y=0xEEF0, slice_carry=0001.
  - All 32 vectors are checked against a+b+cin.
- Wrap/boundary: a=0xFFFF, b=0xFFFF, cin=1 -> y=0xFFFF, cout=1. Also a=0x8000, b=0x8000, cin=0 -> y=0x0000, cout=1, slice_carry=1000.
- Hold: after a valid add, deassert in_valid for 3 cycles -> y/cout unchanged and out_valid=0. Then assert rst mid-stream -> outputs cleared the next cycle.
- Random: 1000 back-to-back random a/b/cin with random in_valid -> scoreboard matches {cout,y}, with 1-cycle latency on every valid input.
